// File: rtl/mux_scan_ctrl.sv
// Serializes an N-bit word onto an Nx1 mux by stepping its select
// LSB-first, DIV clocks per select value, with gapless reload.
module mux_scan_ctrl #(
  parameter int N   = 8,
  parameter int SEL = 3,
  parameter int DIV = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N-1:0]   mux_a,
  output logic [SEL-1:0] mux_s,
  output logic           bit_valid,
  output logic           bit_last,
  output logic           busy
);

  if (N > (1 << SEL)) begin : g_bad_sel
    $error("mux_scan_ctrl: N exceeds 2**SEL");
  end
  if (DIV < 1) begin : g_bad_div
    $error("mux_scan_ctrl: DIV must be >= 1");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [SEL-1:0] S_LAST = SEL'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   mux_a_q, mux_a_d;
  logic [SEL-1:0] mux_s_q, mux_s_d;
  logic           end_bit;
  logic           end_word;
  logic           accept;
  logic           shifting;

  assign shifting = (state_q == SHIFT);
  assign end_word = shifting && end_bit && (mux_s_q == S_LAST);
  assign in_ready = !rst && (!shifting || end_word);
  assign accept   = in_valid && in_ready;

  if (DIV > 1) begin : g_div
    localparam int DW = $clog2(DIV);
    logic [DW-1:0] div_cnt_q, div_cnt_d;

    assign end_bit = (div_cnt_q == DW'(DIV - 1));

    // Counter rests at zero outside SHIFT and after each bit period.
    always_comb begin
      div_cnt_d = '0;
      if (shifting && !end_bit)
        div_cnt_d = div_cnt_q + DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) div_cnt_q <= '0;
      else     div_cnt_q <= div_cnt_d;
    end
  end else begin : g_nodiv
    assign end_bit = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    mux_a_d = mux_a_q;
    mux_s_d = mux_s_q;
    if (accept) begin
      mux_a_d = in_data;
      mux_s_d = '0;
      state_d = SHIFT;
    end else if (shifting && end_bit) begin
      if (mux_s_q != S_LAST)
        mux_s_d = mux_s_q + SEL'(1);
      else
        state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mux_a_q <= '0;
      mux_s_q <= '0;
    end else begin
      state_q <= state_d;
      mux_a_q <= mux_a_d;
      mux_s_q <= mux_s_d;
    end
  end

  assign mux_a     = mux_a_q;
  assign mux_s     = mux_s_q;
  assign bit_valid = shifting;
  assign bit_last  = shifting && (mux_s_q == S_LAST);
  assign busy      = shifting;

endmodule
